// File: rtl/uart_mmio_buffer_pkg.sv
// Shared UART memory map and status layout for the control unit,
// software tests and the byte-buffering stage.
package uart_mmio_buffer_pkg;

    localparam int DefaultDepth = 8;

    localparam logic [3:0] TxDataOffset = 4'h0;
    localparam logic [3:0] RxDataOffset = 4'h4;
    localparam logic [3:0] StatusOffset = 4'h8;

    localparam int StatusInReadyBit  = 0;
    localparam int StatusOutValidBit = 1;
    localparam int StatusOverflowBit = 2;

    typedef struct packed {
        logic rxOverflow;
        logic dataOutValid;
        logic dataInReady;
    } uartStatus_t;

    function automatic logic [7:0] statusWord(input uartStatus_t s);
        logic [7:0] w;
        w = '0;
        w[StatusInReadyBit]  = s.dataInReady;
        w[StatusOutValidBit] = s.dataOutValid;
        w[StatusOverflowBit] = s.rxOverflow;
        return w;
    endfunction

endpackage

// File: rtl/uart_mmio_buffer_sync_fifo.sv
// First-word fall-through FIFO; occupancy is counted separately
// from the pointers so full and empty never alias.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             pushOk;
    logic             popOk;

    assign empty  = (count == '0);
    assign full   = (count == (PTR_W+1)'(DEPTH));
    assign popOk  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign pushOk = push & (~full | popOk);
    assign dout   = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 1'b1;
            if (popOk)  rdPtr <= rdPtr + 1'b1;
            unique case ({pushOk, popOk})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk) mem[wrPtr] <= din;
    end

endmodule

// File: rtl/uart_mmio_buffer.sv
// TX/RX byte buffers between the memory-mapped UART control logic
// and the serial transceiver, with sticky RX overflow detection.
module uart_mmio_buffer
    import uart_mmio_buffer_pkg::*;
#(
    parameter int DEPTH = DefaultDepth,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    input  logic           DataInValid,
    input  logic [7:0]     DataIn,
    output logic           DataInReady,
    input  logic           DataOutReady,
    output logic           DataOutValid,
    output logic [7:0]     UARTDataOut,
    output logic           tx_valid,
    output logic [7:0]     tx_data,
    input  logic           tx_ready,
    input  logic           rx_valid,
    input  logic [7:0]     rx_data,
    output logic           rx_overflow,
    input  logic           clr_overflow,
    output logic [PTR_W:0] tx_count,
    output logic [PTR_W:0] rx_count
);

    logic pushTx;
    logic popTx;
    logic pushRx;
    logic popRx;
    logic txFull;
    logic txEmpty;
    logic rxFull;
    logic rxEmpty;
    logic rxDrop;

    // A stalled pipeline must not commit its UART load/store
    assign pushTx = DataInValid & ~stall;
    assign popRx  = DataOutReady & ~stall;
    assign popTx  = tx_valid & tx_ready;
    assign pushRx = rx_valid;

    assign DataInReady  = ~txFull;
    assign tx_valid     = ~txEmpty;
    assign DataOutValid = ~rxEmpty;

    assign rxDrop = pushRx & rxFull & ~popRx;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8), .PTR_W(PTR_W)) tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pushTx),
        .pop   (popTx),
        .din   (DataIn),
        .dout  (tx_data),
        .full  (txFull),
        .empty (txEmpty),
        .count (tx_count)
    );

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8), .PTR_W(PTR_W)) rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pushRx),
        .pop   (popRx),
        .din   (rx_data),
        .dout  (UARTDataOut),
        .full  (rxFull),
        .empty (rxEmpty),
        .count (rx_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_overflow <= 1'b0;
        end else if (rxDrop) begin
            rx_overflow <= 1'b1;
        end else if (clr_overflow) begin
            rx_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_mmio_buffer.sv
// Scoreboard bench for uart_mmio_buffer: directed scenarios followed by
// randomized traffic against a queue-based reference model.
module tb_uart_mmio_buffer;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       DataInValid;
    logic [7:0] DataIn;
    logic       DataInReady;
    logic       DataOutReady;
    logic       DataOutValid;
    logic [7:0] UARTDataOut;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_overflow;
    logic       clr_overflow;
    logic [3:0] tx_count;
    logic [3:0] rx_count;

    int total = 0;
    int bad = 0;

    logic [7:0] expTx[$];
    logic [7:0] expRx[$];
    bit         expOvf;
    bit         monEn;

    uart_mmio_buffer #(.DEPTH(DEPTH), .PTR_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .DataInValid  (DataInValid),
        .DataIn       (DataIn),
        .DataInReady  (DataInReady),
        .DataOutReady (DataOutReady),
        .DataOutValid (DataOutValid),
        .UARTDataOut  (UARTDataOut),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_overflow  (rx_overflow),
        .clr_overflow (clr_overflow),
        .tx_count     (tx_count),
        .rx_count     (rx_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares flags, counts and heads, consumes on handshakes
    always @(negedge clk) begin
        if (monEn && !rst) begin
            check("txCount", 32'(tx_count), 32'(expTx.size()));
            check("rxCount", 32'(rx_count), 32'(expRx.size()));
            check("inReady", 32'(DataInReady), 32'(expTx.size() < DEPTH));
            check("txValid", 32'(tx_valid), 32'(expTx.size() != 0));
            check("outValid", 32'(DataOutValid), 32'(expRx.size() != 0));
            check("overflow", 32'(rx_overflow), 32'(expOvf));
            if (expTx.size() != 0) begin
                check("txData", 32'(tx_data), 32'(expTx[0]));
                if (tx_ready) void'(expTx.pop_front());
            end
            if (expRx.size() != 0) begin
                check("rxData", 32'(UARTDataOut), 32'(expRx[0]));
                if (DataOutReady && !stall) void'(expRx.pop_front());
            end
        end
    end

    // Runs after the monitor has retired this cycle's pops
    task automatic modelUpdate();
        bit drop;
        drop = 1'b0;
        if (DataInValid && !stall && expTx.size() < DEPTH)
            expTx.push_back(DataIn);
        if (rx_valid) begin
            if (expRx.size() < DEPTH) expRx.push_back(rx_data);
            else drop = 1'b1;
        end
        if (drop) expOvf = 1'b1;
        else if (clr_overflow) expOvf = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        modelUpdate();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(input bit div, input logic [7:0] di,
                         input bit dor, input bit st, input bit txr,
                         input bit rxv, input logic [7:0] rxd,
                         input bit clr);
        DataInValid  = div;
        DataIn       = di;
        DataOutReady = dor;
        stall        = st;
        tx_ready     = txr;
        rx_valid     = rxv;
        rx_data      = rxd;
        clr_overflow = clr;
    endtask

    task automatic idle();
        setIn(0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
    endtask

    initial begin
        int rIn, rOut, rTx, rRx, rSt;
        monEn = 1'b0;
        expOvf = 1'b0;
        rst = 1'b1;
        idle();
        #2;
        check("rstInReady", 32'(DataInReady), 32'd1);
        check("rstOutValid", 32'(DataOutValid), 32'd0);
        check("rstTxValid", 32'(tx_valid), 32'd0);
        check("rstTxCount", 32'(tx_count), 32'd0);
        check("rstRxCount", 32'(rx_count), 32'd0);
        check("rstOvf", 32'(rx_overflow), 32'd0);
        check("rstTxData", 32'(tx_data), 32'd0);
        check("rstRxData", 32'(UARTDataOut), 32'd0);
        #10;
        rst = 1'b0;
        monEn = 1'b1;
        @(posedge clk);
        #1;

        // TX fill, dropped 9th push, drain
        for (int i = 0; i < 8; i++) begin
            setIn(1, 8'(i), 0, 0, 0, 0, 8'h00, 0);
            step();
        end
        check("fillCount", 32'(tx_count), 32'd8);
        check("fillReady", 32'(DataInReady), 32'd0);
        setIn(1, 8'hFF, 0, 0, 0, 0, 8'h00, 0);
        step();
        check("dropCount", 32'(tx_count), 32'd8);
        for (int i = 0; i < 9; i++) begin
            setIn(0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
            step();
        end
        check("drainValid", 32'(tx_valid), 32'd0);

        // Full TX with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            setIn(1, 8'(8'h30 + i), 0, 0, 0, 0, 8'h00, 0);
            step();
        end
        setIn(1, 8'hAA, 0, 0, 1, 0, 8'h00, 0);
        step();
        check("fullPushPop", 32'(tx_count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            setIn(0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
            step();
        end
        idle();
        step();

        // RX overflow and clear
        for (int i = 0; i < 9; i++) begin
            setIn(0, 8'h00, 0, 0, 0, 1, 8'(8'h10 + i), 0);
            step();
        end
        check("ovfCount", 32'(rx_count), 32'd8);
        check("ovfSet", 32'(rx_overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            setIn(0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
            step();
        end
        check("ovfHeld", 32'(rx_overflow), 32'd1);
        setIn(0, 8'h00, 0, 0, 0, 0, 8'h00, 1);
        step();
        check("ovfClr", 32'(rx_overflow), 32'd0);

        // Empty RX push+pop
        setIn(0, 8'h00, 1, 0, 0, 1, 8'h5A, 0);
        step();
        check("emptyPpCount", 32'(rx_count), 32'd1);
        check("emptyPpData", 32'(UARTDataOut), 32'h5A);
        setIn(0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        step();

        // Stall masks CPU-side pops
        setIn(0, 8'h00, 0, 0, 0, 1, 8'h61, 0);
        step();
        setIn(0, 8'h00, 0, 0, 0, 1, 8'h62, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            setIn(1, 8'hEE, 1, 1, 0, 0, 8'h00, 0);
            step();
        end
        check("stallRx", 32'(rx_count), 32'd2);
        check("stallTx", 32'(tx_count), 32'd0);
        setIn(0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        step();
        check("unstallData", 32'(UARTDataOut), 32'h62);
        step();
        idle();
        step();

        // Asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) begin
            setIn(1, 8'(8'h70 + i), 0, 0, 0, 0, 8'h00, 0);
            step();
        end
        idle();
        #2;
        rst = 1'b1;
        #1;
        check("arstTxValid", 32'(tx_valid), 32'd0);
        check("arstTxCount", 32'(tx_count), 32'd0);
        check("arstInReady", 32'(DataInReady), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        expTx.delete();
        expRx.delete();
        expOvf = 1'b0;
        @(posedge clk);
        #1;
        setIn(1, 8'h41, 0, 0, 0, 0, 8'h00, 0);
        step();
        check("postRstHead", 32'(tx_data), 32'h41);
        setIn(1, 8'h42, 0, 0, 1, 0, 8'h00, 0);
        step();
        setIn(0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
        step();
        step();

        // Randomized traffic with per-block rates
        for (int b = 0; b < 15; b++) begin
            rIn  = $urandom_range(10, 90);
            rOut = $urandom_range(10, 90);
            rTx  = $urandom_range(10, 90);
            rRx  = $urandom_range(10, 90);
            rSt  = $urandom_range(0, 40);
            for (int c = 0; c < 200; c++) begin
                setIn($urandom_range(0, 99) < rIn, 8'($urandom),
                      $urandom_range(0, 99) < rOut,
                      $urandom_range(0, 99) < rSt,
                      $urandom_range(0, 99) < rTx,
                      $urandom_range(0, 99) < rRx, 8'($urandom),
                      $urandom_range(0, 99) < 8);
                step();
            end
        end
        idle();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
